// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation controller:
// default widths, FSM state encoding and the Montgomery "one" operand.
`default_nettype none

package mont_pkg;

    localparam int DW = 512;
    localparam int EW = 512;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_TOMONT        = 4'd1,
        ST_WAIT_TOMONT   = 4'd2,
        ST_SQR           = 4'd3,
        ST_WAIT_SQR      = 4'd4,
        ST_MUL           = 4'd5,
        ST_WAIT_MUL      = 4'd6,
        ST_FROMMONT      = 4'd7,
        ST_WAIT_FROMMONT = 4'd8,
        ST_FIN           = 4'd9
    } state_t;

    // Width of a counter able to hold EW-1, never narrower than one bit.
    function automatic int idx_width(input int ew);
        return (ew > 1) ? $clog2(ew) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M by driving
// an external Montgomery multiplier through the mul_* handshake.
`default_nettype none

module mont_exp_ctrl
    import mont_pkg::*;
#(
    parameter int DW = mont_pkg::DW,
    parameter int EW = mont_pkg::EW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [DW-1:0] in_x,
    input  logic [EW-1:0] in_e,
    input  logic [DW-1:0] in_m,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_r2,
    output logic [DW-1:0] result,
    output logic          done,
    output logic          busy,
    output logic          mul_start,
    output logic [DW-1:0] mul_a,
    output logic [DW-1:0] mul_b,
    output logic [DW-1:0] mul_m,
    input  logic [DW-1:0] mul_result,
    input  logic          mul_done
);

    localparam int            IW      = idx_width(EW);
    localparam logic [IW-1:0] IDX_TOP = IW'(EW - 1);
    localparam logic [DW-1:0] MUL_ONE = DW'(ONE);

    state_t        state;
    state_t        next_state;

    logic [DW-1:0] op_x;
    logic [EW-1:0] op_e;
    logic [DW-1:0] op_m;
    logic [DW-1:0] op_r;
    logic [DW-1:0] op_r2;
    logic [DW-1:0] xt;
    logic [DW-1:0] acc;
    logic [IW-1:0] bit_idx;
    logic [DW-1:0] result_q;

    logic          accept;
    logic          init_acc;
    logic          load_xt;
    logic          load_acc;
    logic          load_result;
    logic          dec_idx;
    logic          last_bit;

    assign last_bit = (bit_idx == '0);
    assign result   = result_q;
    assign mul_m    = op_m;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            op_x     <= '0;
            op_e     <= '0;
            op_m     <= '0;
            op_r     <= '0;
            op_r2    <= '0;
            xt       <= '0;
            acc      <= '0;
            bit_idx  <= '0;
            result_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_x    <= in_x;
                op_e    <= in_e;
                op_m    <= in_m;
                op_r    <= in_r;
                op_r2   <= in_r2;
                bit_idx <= IDX_TOP;
            end
            if (init_acc) begin
                acc <= op_r;
            end
            if (load_xt) begin
                xt <= mul_result;
            end
            if (load_acc) begin
                acc <= mul_result;
            end
            if (dec_idx) begin
                bit_idx <= bit_idx - 1'b1;
            end
            // Result is taken straight from the final product so it is
            // already valid during the FIN cycle that carries the done pulse.
            if (load_result) begin
                result_q <= mul_result;
            end
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        init_acc    = 1'b0;
        load_xt     = 1'b0;
        load_acc    = 1'b0;
        load_result = 1'b0;
        dec_idx     = 1'b0;
        mul_start   = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        done        = 1'b0;
        busy        = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_TOMONT;
                end
            end
            ST_TOMONT: begin
                mul_start  = 1'b1;
                mul_a      = op_x;
                mul_b      = op_r2;
                init_acc   = 1'b1;
                next_state = ST_WAIT_TOMONT;
            end
            ST_WAIT_TOMONT: begin
                mul_a = op_x;
                mul_b = op_r2;
                if (mul_done) begin
                    load_xt    = 1'b1;
                    next_state = ST_SQR;
                end
            end
            ST_SQR: begin
                mul_start  = 1'b1;
                mul_a      = acc;
                mul_b      = acc;
                next_state = ST_WAIT_SQR;
            end
            ST_WAIT_SQR: begin
                mul_a = acc;
                mul_b = acc;
                if (mul_done) begin
                    load_acc = 1'b1;
                    if (op_e[bit_idx]) begin
                        next_state = ST_MUL;
                    end else if (last_bit) begin
                        next_state = ST_FROMMONT;
                    end else begin
                        dec_idx    = 1'b1;
                        next_state = ST_SQR;
                    end
                end
            end
            ST_MUL: begin
                mul_start  = 1'b1;
                mul_a      = acc;
                mul_b      = xt;
                next_state = ST_WAIT_MUL;
            end
            ST_WAIT_MUL: begin
                mul_a = acc;
                mul_b = xt;
                if (mul_done) begin
                    load_acc = 1'b1;
                    if (last_bit) begin
                        next_state = ST_FROMMONT;
                    end else begin
                        dec_idx    = 1'b1;
                        next_state = ST_SQR;
                    end
                end
            end
            ST_FROMMONT: begin
                mul_start  = 1'b1;
                mul_a      = acc;
                mul_b      = MUL_ONE;
                next_state = ST_WAIT_FROMMONT;
            end
            ST_WAIT_FROMMONT: begin
                mul_a = acc;
                mul_b = MUL_ONE;
                if (mul_done) begin
                    load_acc    = 1'b1;
                    load_result = 1'b1;
                    next_state  = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
// Directed self-checking bench for mont_exp_ctrl with a behavioural
// Montgomery multiplier of programmable latency.
`default_nettype none

module tb_mont_exp_ctrl;

    localparam int DW = mont_pkg::DW;
    localparam int EW = mont_pkg::EW;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [DW-1:0] in_x;
    logic [EW-1:0] in_e;
    logic [DW-1:0] in_m;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_r2;
    logic [DW-1:0] result;
    logic          done;
    logic          busy;
    logic          mul_start;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] mul_m;
    logic [DW-1:0] mul_result;
    logic          mul_done;

    mont_exp_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_x       (in_x),
        .in_e       (in_e),
        .in_m       (in_m),
        .in_r       (in_r),
        .in_r2      (in_r2),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_count = 0;
    int            start_count = 0;
    int            stab_errs = 0;
    int            model_count = 0;
    int            lat_base = 1;
    bit            slow_mode = 1'b0;
    logic [DW-1:0] done_result = '0;
    logic [DW-1:0] cur_m = '0;

    // Reference Montgomery product a*b*2^-DW mod m (bit-serial REDC).
    function automatic logic [DW-1:0] mm(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] m);
        logic [DW+1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        p = p % {{DW{1'b0}}, m};
        return p[DW-1:0];
    endfunction

    // Plain modular exponentiation, independent of the Montgomery domain.
    function automatic logic [DW-1:0] modexp(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                             input logic [DW-1:0] m);
        logic [DW-1:0] a;
        a = 1;
        for (int i = EW - 1; i >= 0; i--) begin
            a = mulmod(a, a, m);
            if (e[i]) a = mulmod(a, x, m);
        end
        return a;
    endfunction

    function automatic logic [DW-1:0] r_mod(input logic [DW-1:0] m);
        logic [2*DW-1:0] big;
        big = '0;
        big[DW] = 1'b1;
        big = big % {{DW{1'b0}}, m};
        return big[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_mod();
        logic [DW-1:0] v;
        v = rand_dw();
        v[DW-1] = 1'b0;
        v[DW-2] = 1'b1;
        v[0]    = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_base();
        logic [DW-1:0] v;
        v = rand_dw();
        v[DW-1:DW-3] = 3'b000;
        return v;
    endfunction

    function automatic int latency_of(input int n);
        if (slow_mode && (n <= 4 || (n % 128) == 0)) return 600;
        return lat_base;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                done_result = result;
            end
            if (mul_start === 1'b1) start_count++;
        end
    end

    // Behavioural multiplier: captures operands on mul_start, checks they
    // stay put while it works, then pulses mul_done with the product.
    initial begin
        logic [DW-1:0] cap_a;
        logic [DW-1:0] cap_b;
        logic [DW-1:0] prod;
        int            lat;
        mul_done   = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk);
            #1;
            while (mul_start === 1'b1) begin
                cap_a = mul_a;
                cap_b = mul_b;
                if (mul_m !== cur_m) stab_errs++;
                prod = mm(cap_a, cap_b, cur_m);
                model_count++;
                lat = latency_of(model_count);
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                    if (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cur_m) stab_errs++;
                end
                mul_result = prod;
                mul_done   = 1'b1;
                @(posedge clk);
                #1;
                mul_done   = 1'b0;
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic run_op(input logic [DW-1:0] x, input logic [EW-1:0] e,
                          input logic [DW-1:0] m, input bit hold_start,
                          output logic [DW-1:0] res, output logic [DW-1:0] held,
                          output int nmul, output int ndone, output int stab);
        logic [DW-1:0] r;
        bit            ok;
        r           = r_mod(m);
        cur_m       = m;
        start_count = 0;
        done_count  = 0;
        stab_errs   = 0;
        model_count = 0;
        in_x  = x;
        in_e  = e;
        in_m  = m;
        in_r  = r;
        in_r2 = mulmod(r, r, m);
        start = 1'b1;
        ok    = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk);
            #1;
            if (hold_start) begin
                start = 1'b1;
                in_x  = rand_dw();
                in_e  = EW'($urandom);
                in_r  = rand_dw();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done_count > 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        res   = done_result;
        held  = result;
        nmul  = start_count;
        ndone = done_count;
        stab  = stab_errs;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL op_timeout: done seen=%0d required=1 within 30000 cycles", done_count);
            pulse_reset();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        in_x = '0; in_e = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (result !== '0)    begin n_bad++; $display("FAIL rst_result: got %0h want 0", result); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL rst_mul_start: got %b want 0", mul_start); end
        n_cmp++; if (mul_a !== '0)     begin n_bad++; $display("FAIL rst_mul_a: got %0h want 0", mul_a); end
        n_cmp++; if (mul_b !== '0)     begin n_bad++; $display("FAIL rst_mul_b: got %0h want 0", mul_b); end
        n_cmp++; if (mul_m !== '0)     begin n_bad++; $display("FAIL rst_mul_m: got %0h want 0", mul_m); end
    endtask

    task automatic test_e0();
        logic [DW-1:0] m, res, held;
        int nmul, ndone, stab;
        m = rand_mod();
        resetn = 1'b1;
        run_op(512'd5, '0, m, 1'b0, res, held, nmul, ndone, stab);
        n_cmp++; if (res !== 512'd1)  begin n_bad++; $display("FAIL e0_result: got %0h want 1", res); end
        n_cmp++; if (held !== 512'd1) begin n_bad++; $display("FAIL e0_result_held: got %0h want 1", held); end
        n_cmp++; if (nmul !== 514)    begin n_bad++; $display("FAIL e0_mul_count: got %0d want 514", nmul); end
        n_cmp++; if (ndone !== 1)     begin n_bad++; $display("FAIL e0_done_pulses: got %0d want 1", ndone); end
        n_cmp++; if (stab !== 0)      begin n_bad++; $display("FAIL e0_operand_stability: got %0d errors want 0", stab); end
    endtask

    task automatic test_e1();
        logic [DW-1:0] m, res, held;
        int nmul, ndone, stab;
        m = rand_mod();
        run_op(512'h1234, EW'(1), m, 1'b0, res, held, nmul, ndone, stab);
        n_cmp++; if (res !== 512'h1234) begin n_bad++; $display("FAIL e1_result: got %0h want 1234", res); end
        n_cmp++; if (nmul !== 515)      begin n_bad++; $display("FAIL e1_mul_count: got %0d want 515", nmul); end
        n_cmp++; if (ndone !== 1)       begin n_bad++; $display("FAIL e1_done_pulses: got %0d want 1", ndone); end
    endtask

    task automatic test_e65537();
        logic [DW-1:0] m, x, res, held, want;
        int nmul, ndone, stab;
        m    = rand_mod();
        x    = rand_base();
        want = modexp(x, EW'(32'h10001), m);
        run_op(x, EW'(32'h10001), m, 1'b0, res, held, nmul, ndone, stab);
        n_cmp++; if (res !== want) begin n_bad++; $display("FAIL e65537_result: got %0h want %0h", res, want); end
        n_cmp++; if (nmul !== 516) begin n_bad++; $display("FAIL e65537_mul_count: got %0d want 516", nmul); end
        n_cmp++; if (stab !== 0)   begin n_bad++; $display("FAIL e65537_operand_stability: got %0d errors want 0", stab); end
    endtask

    task automatic test_start_hold();
        logic [DW-1:0] m, res, held;
        int nmul, ndone, stab;
        m = rand_mod();
        run_op(512'd7, EW'(3), m, 1'b1, res, held, nmul, ndone, stab);
        n_cmp++; if (res !== 512'd343)  begin n_bad++; $display("FAIL hold_result: got %0h want 157", res); end
        n_cmp++; if (held !== 512'd343) begin n_bad++; $display("FAIL hold_result_held: got %0h want 157", held); end
        n_cmp++; if (nmul !== 516)      begin n_bad++; $display("FAIL hold_mul_count: got %0d want 516", nmul); end
        n_cmp++; if (ndone !== 1)       begin n_bad++; $display("FAIL hold_done_pulses: got %0d want 1", ndone); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL hold_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] m, x, res, held, want, r;
        int nmul, ndone, stab, seen_starts, seen_done;
        bit reached;
        m = rand_mod();
        x = rand_base();
        r = r_mod(m);
        lat_base    = 20;
        cur_m       = m;
        start_count = 0;
        done_count  = 0;
        model_count = 0;
        @(posedge clk);
        #1;
        in_x = x; in_e = EW'(32'h10001); in_m = m; in_r = r; in_r2 = mulmod(r, r, m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (start_count >= 100) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (!reached) begin n_bad++; $display("FAIL rmid_reach_100: got %0d multiplies want 100", start_count); end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (result !== '0)      begin n_bad++; $display("FAIL rmid_result: got %0h want 0", result); end
        n_cmp++; if (mul_a !== '0 || mul_b !== '0 || mul_m !== '0 || mul_start !== 1'b0)
                 begin n_bad++; $display("FAIL rmid_mul_outputs: got a=%0h b=%0h m=%0h start=%b want all 0", mul_a, mul_b, mul_m, mul_start); end
        seen_starts = start_count;
        seen_done   = done_count;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++; if (done_count !== seen_done) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_count - seen_done); end
        n_cmp++; if (busy !== 1'b0 || start_count !== seen_starts)
                 begin n_bad++; $display("FAIL rmid_stray_ignored: got busy=%b new_mul_starts=%0d want 0/0", busy, start_count - seen_starts); end
        lat_base = 1;
        want = modexp(x, EW'(32'h10001), m);
        run_op(x, EW'(32'h10001), m, 1'b0, res, held, nmul, ndone, stab);
        n_cmp++; if (res !== want) begin n_bad++; $display("FAIL rmid_fresh_result: got %0h want %0h", res, want); end
        n_cmp++; if (nmul !== 516) begin n_bad++; $display("FAIL rmid_fresh_mul_count: got %0d want 516", nmul); end
    endtask

    task automatic test_latency();
        logic [DW-1:0] m, x, want, res_fast, res_slow, held;
        int nmul_f, nmul_s, ndone, stab_f, stab_s;
        m    = rand_mod();
        x    = rand_base();
        want = modexp(x, EW'(5), m);
        lat_base  = 1;
        slow_mode = 1'b0;
        run_op(x, EW'(5), m, 1'b0, res_fast, held, nmul_f, ndone, stab_f);
        slow_mode = 1'b1;
        run_op(x, EW'(5), m, 1'b0, res_slow, held, nmul_s, ndone, stab_s);
        slow_mode = 1'b0;
        n_cmp++; if (res_fast !== want)     begin n_bad++; $display("FAIL lat_fast_result: got %0h want %0h", res_fast, want); end
        n_cmp++; if (res_slow !== res_fast) begin n_bad++; $display("FAIL lat_slow_vs_fast: got %0h want %0h", res_slow, res_fast); end
        n_cmp++; if (stab_f !== 0 || stab_s !== 0)
                 begin n_bad++; $display("FAIL lat_operand_stability: got %0d/%0d errors want 0/0", stab_f, stab_s); end
        n_cmp++; if (nmul_s !== 516)        begin n_bad++; $display("FAIL lat_slow_mul_count: got %0d want 516", nmul_s); end
    endtask

    initial begin
        test_reset();
        test_e0();
        test_e1();
        test_e65537();
        test_start_hold();
        test_reset_mid();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
